// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: signals between the keypad scanner, the keypad matrix
// and the lock FSM that consumes key codes.
//   master : the scanner (drives columns and key reports, reads rows)
//   slave  : keypad/consumer side (drives rows, reads columns and reports)
`timescale 1ns/1ps

interface keypad_scanner_if;
  logic [3:0] row;        // active-low row lines from the matrix
  logic [3:0] col;        // active-low column drive, one bit low at a time
  logic [3:0] key;        // {row_idx, col_idx} of the last accepted key
  logic       key_valid;  // one-cycle strobe when key is (re)reported
  logic       key_held;   // high while the accepted key is still down

  modport master (
    input  row,
    output col, key, key_valid, key_held
  );

  modport slave (
    output row,
    input  col, key, key_valid, key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce.
// Drives one active-low column at a time, samples the rows once per column
// period, debounces presses and releases, and reports each accepted key as
// a 4-bit {row, col} code with a one-cycle key_valid strobe.
// Optional feature macro: KEYPAD_REPEAT_EN -- when defined, a held key
// re-strobes key_valid every REPEAT_CNT sample ticks.
`timescale 1ns/1ps

module keypad_scanner #(
  parameter int SCAN_DIV     = 4,  // clk cycles per column, >= 4
  parameter int DEBOUNCE_CNT = 3,  // matching samples to accept press/release
  parameter int REPEAT_CNT   = 8   // ticks between auto-repeat strobes
) (
  input  logic              clk,
  input  logic              rst,
  keypad_scanner_if.master  kp
);

  localparam int CNT_MAX = (DEBOUNCE_CNT > REPEAT_CNT) ? DEBOUNCE_CNT : REPEAT_CNT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int DW      = $clog2(SCAN_DIV);

  localparam logic [CW-1:0] DEB_TGT  = CW'(DEBOUNCE_CNT);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
`ifdef KEYPAD_REPEAT_EN
  localparam logic [CW-1:0] REP_TGT  = CW'(REPEAT_CNT);
`endif

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      row_q1, row_s;
  logic [DW-1:0]   div_q;
  logic            tick;
  logic [1:0]      col_idx_q, col_idx_d;
  logic [1:0]      cand_row_q, cand_row_d;
  logic [1:0]      cand_col_q, cand_col_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [3:0]      key_q, key_d;
  logic            key_valid_q, key_valid_d;
  logic            key_held_q, key_held_d;
  logic [1:0]      row_idx;
  logic            sample_valid;
  logic            sample_idle;
`ifdef KEYPAD_REPEAT_EN
  logic [CW-1:0]   rep_q, rep_d, rep_inc;
`endif

  // Saturating increment shared by the debounce and repeat counters.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  assign tick    = (div_q == DIV_LAST);
  assign cnt_inc = sat_inc(cnt_q);
`ifdef KEYPAD_REPEAT_EN
  assign rep_inc = sat_inc(rep_q);
`endif

  // Two-flop row synchroniser and column-period divider.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q1 <= 4'hF;
      row_s  <= 4'hF;
      div_q  <= '0;
    end else begin
      row_q1 <= kp.row;
      row_s  <= row_q1;
      div_q  <= tick ? '0 : div_q + DW'(1);
    end
  end

  // Classify the synchronised rows: exactly one low is a valid press.
  always_comb begin
    row_idx      = 2'd0;
    sample_valid = 1'b0;
    case (row_s)
      4'b1110: begin row_idx = 2'd0; sample_valid = 1'b1; end
      4'b1101: begin row_idx = 2'd1; sample_valid = 1'b1; end
      4'b1011: begin row_idx = 2'd2; sample_valid = 1'b1; end
      4'b0111: begin row_idx = 2'd3; sample_valid = 1'b1; end
      default: begin row_idx = 2'd0; sample_valid = 1'b0; end
    endcase
  end

  assign sample_idle = &row_s;

  // FSM state, column pointer, debounce counters and key report registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SCAN;
      col_idx_q   <= 2'd0;
      cand_row_q  <= 2'd0;
      cand_col_q  <= 2'd0;
      cnt_q       <= '0;
      key_q       <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      cand_row_q  <= cand_row_d;
      cand_col_q  <= cand_col_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= rep_d;
`endif
    end
  end

  // Next-state and datapath decisions; everything only moves on a tick.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    cand_row_d  = cand_row_q;
    cand_col_d  = cand_col_q;
    cnt_d       = cnt_q;
    key_d       = key_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
`ifdef KEYPAD_REPEAT_EN
    rep_d       = rep_q;
`endif

    if (tick) begin
      case (state_q)
        SCAN: begin
          if (sample_valid) begin
            cand_row_d = row_idx;
            cand_col_d = col_idx_q;
            cnt_d      = CW'(1);
            if (DEBOUNCE_CNT == 1) begin
              state_d     = PRESSED;
              key_d       = {row_idx, col_idx_q};
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
              rep_d       = '0;
`endif
            end else begin
              state_d = DEBOUNCE;
            end
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end

        DEBOUNCE: begin
          if (sample_valid && (row_idx == cand_row_q)) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DEB_TGT) begin
              state_d     = PRESSED;
              cnt_d       = '0;
              key_d       = {cand_row_q, cand_col_q};
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
              rep_d       = '0;
`endif
            end
          end else begin
            state_d   = SCAN;
            cnt_d     = '0;
            col_idx_d = col_idx_q + 2'd1;
          end
        end

        PRESSED: begin
          if (sample_idle) begin
            if (DEBOUNCE_CNT == 1) begin
              state_d    = SCAN;
              cnt_d      = '0;
              key_held_d = 1'b0;
              col_idx_d  = col_idx_q + 2'd1;
            end else begin
              state_d = RELEASE;
              cnt_d   = CW'(1);
            end
          end else begin
`ifdef KEYPAD_REPEAT_EN
            // Still held: count ticks and re-strobe the same key.
            if (rep_inc >= REP_TGT) begin
              key_valid_d = 1'b1;
              rep_d       = '0;
            end else begin
              rep_d = rep_inc;
            end
`endif
          end
        end

        RELEASE: begin
          if (sample_idle) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DEB_TGT) begin
              state_d    = SCAN;
              cnt_d      = '0;
              key_held_d = 1'b0;
              col_idx_d  = col_idx_q + 2'd1;
            end
          end else begin
            // Release bounce: key is still down, no new strobe.
            state_d = PRESSED;
            cnt_d   = '0;
`ifdef KEYPAD_REPEAT_EN
            rep_d   = '0;
`endif
          end
        end

        default: state_d = SCAN;
      endcase
    end
  end

  assign kp.col       = ~(4'b0001 << col_idx_q);
  assign kp.key       = key_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives a simulated 4x4 key matrix and compares the
// scanner's outputs every cycle against a tick-level behavioural model.
`timescale 1ns/1ps

module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int REP      = 8;
`ifdef KEYPAD_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  keypad_scanner_if kp_if ();

  keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEB),
    .REPEAT_CNT   (REP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp_if)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [15:0] pressed;      // bit r*4+c set = key {r,c} physically down
  int          cyc;          // cycles since reset release
  logic [3:0]  h_m1, h_m2;   // rows driven one and two cycles ago

  // Reference model, advanced once per sample tick.
  bit         m_held;
  int         m_streak;
  int         m_rel;
  int         m_rep;
  int         m_col;
  logic [1:0] m_cand_row;
  logic [1:0] m_cand_col;
  logic [3:0] m_key;
  bit         m_valid;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Physical matrix: a row reads low if any pressed key on it sits in a
  // column that is currently driven low.
  function automatic logic [3:0] keypad_rows(input logic [15:0] p, input logic [3:0] c);
    logic [3:0] r_out;
    r_out = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int cc = 0; cc < 4; cc++)
        if (p[r*4 + cc] && !c[cc]) r_out[r] = 1'b0;
    return r_out;
  endfunction

  task automatic model_reset();
    m_held = 1'b0; m_streak = 0; m_rel = 0; m_rep = 0; m_col = 0;
    m_cand_row = 2'd0; m_cand_col = 2'd0; m_key = 4'h0; m_valid = 1'b0;
  endtask

  // One sample tick: decides the outputs seen in the following cycle.
  task automatic model_tick(input logic [3:0] s);
    int  n_low;
    int  ridx;
    bit  valid;
    bit  idle;
    n_low = 0;
    ridx  = 0;
    for (int i = 0; i < 4; i++)
      if (!s[i]) begin n_low++; ridx = i; end
    valid   = (n_low == 1);
    idle    = (n_low == 0);
    m_valid = 1'b0;
    if (!m_held) begin
      if (m_streak > 0 && valid && 2'(ridx) == m_cand_row) begin
        m_streak++;
      end else if (m_streak == 0 && valid) begin
        m_streak   = 1;
        m_cand_row = 2'(ridx);
        m_cand_col = 2'(m_col);
      end else begin
        m_streak = 0;
        m_col    = (m_col + 1) % 4;
      end
      if (m_streak >= DEB) begin
        m_held   = 1'b1;
        m_streak = 0;
        m_key    = {m_cand_row, m_cand_col};
        m_valid  = 1'b1;
        m_rep    = 0;
        m_rel    = 0;
      end
    end else begin
      if (idle) begin
        m_rel++;
        if (m_rel >= DEB) begin
          m_held = 1'b0;
          m_rel  = 0;
          m_col  = (m_col + 1) % 4;
        end
      end else begin
        if (m_rel > 0) begin
          m_rep = 0;
        end else if (REP_EN) begin
          m_rep++;
          if (m_rep == REP) begin
            m_valid = 1'b1;
            m_rep   = 0;
          end
        end
        m_rel = 0;
      end
    end
  endtask

  // Mid-cycle work: compare outputs, advance the model, drive the rows.
  task automatic do_cycle();
    logic [3:0] exp_col;
    logic [3:0] row_now;
    exp_col = ~(4'b0001 << m_col);
    check("col", kp_if.col, exp_col);
    check("key", kp_if.key, m_key);
    check("key_valid", {3'b000, kp_if.key_valid}, {3'b000, m_valid});
    check("key_held", {3'b000, kp_if.key_held}, {3'b000, m_held});
    if (cyc % SCAN_DIV == SCAN_DIV - 1) model_tick(h_m2);
    else m_valid = 1'b0;
    row_now   = keypad_rows(pressed, kp_if.col);
    kp_if.row = row_now;
    h_m2 = h_m1;
    h_m1 = row_now;
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      do_cycle();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    kp_if.row = keypad_rows(pressed, kp_if.col);
    @(negedge clk);
    check("rst_col", kp_if.col, 4'b1110);
    check("rst_key", kp_if.key, 4'h0);
    check("rst_key_valid", {3'b000, kp_if.key_valid}, 4'h0);
    check("rst_key_held", {3'b000, kp_if.key_held}, 4'h0);
    @(negedge clk);
    rst  = 1'b0;
    cyc  = 0;
    h_m1 = 4'hF;
    h_m2 = 4'hF;
    model_reset();
    do_cycle();
  endtask

  initial begin
    logic [15:0] rnd;
    int          sel;
    rst       = 1'b1;
    pressed   = 16'h0000;
    kp_if.row = 4'hF;
    cyc       = 0;
    model_reset();

    // Reset, then idle rotation through all columns.
    do_reset();
    run(40);

    // Key A (row 2, col 2): single strobe, frozen column, then release.
    pressed = 16'h0400;
    run(60);
    pressed = 16'h0000;
    run(40);

    // Row 1 bouncing one tick down, one tick up.
    for (int i = 0; i < 10; i++) begin
      pressed = 16'h0020; run(4);
      pressed = 16'h0000; run(4);
    end
    run(20);

    // Two rows low in the same column (keys 2 and 6).
    pressed = 16'h0044;
    run(60);
    pressed = 16'h0000;
    run(20);

    // Ghosting pattern across three corners.
    pressed = 16'h0013;
    run(60);
    pressed = 16'h0000;
    run(40);

    // Second key while the first is held is ignored.
    pressed = 16'h0008;
    run(40);
    pressed = 16'h1008;
    run(40);
    pressed = 16'h1000;
    run(80);
    pressed = 16'h0000;
    run(40);

    // Reset while a key is held.
    pressed = 16'h0400;
    run(50);
    do_reset();
    run(60);
    pressed = 16'h0000;
    run(40);

    // Long hold of key 5 (auto-repeat when enabled).
    pressed = 16'h0020;
    run(150);
    pressed = 16'h0000;
    run(40);

    // Random bounce on key 9.
    for (int i = 0; i < 30; i++) begin
      pressed = ($urandom_range(0, 1) == 1) ? 16'h0200 : 16'h0000;
      run($urandom_range(1, 12));
    end
    pressed = 16'h0000;
    run(40);

    // Random key patterns and hold times.
    for (int i = 0; i < 25; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6) begin
        pressed = 16'h0001 << $urandom_range(0, 15);
      end else if (sel < 8) begin
        pressed = 16'h0000;
      end else begin
        rnd     = 16'($urandom()) & 16'($urandom()) & 16'($urandom());
        pressed = rnd;
      end
      run($urandom_range(5, 120));
    end
    pressed = 16'h0000;
    run(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad for the digital lock. It drives one active-low column at a time and samples four active-low row lines. Row data is synchronised and debounced, and each accepted keypress is reported as a 4-bit code with a one-cycle strobe. It is the input-side counterpart of the multiplexed seven-segment display driver and feeds key codes to the lock FSM.

## Interface
- SCAN_DIV, 4: clk cycles each column is driven; minimum 4.
- DEBOUNCE_CNT, 3: consecutive matching samples needed to accept a press or a release; minimum 1.
- REPEAT_CNT, 8: samples between auto-repeat strobes; used only when KEYPAD_REPEAT_EN is defined.
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- row  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
- col  output  4  column drive, active-low, exactly one bit low at all times.
- key  output  4  code of the last accepted key: {row_idx[1:0], col_idx[1:0]}.
- key_valid  output  1  one-cycle strobe, asserted when key is updated.
- key_held  output  1  high while an accepted key remains pressed.

## Operation
- row passes through a 2-flop synchroniser to give row_s.
- Divider counts 0..SCAN_DIV-1. The cycle where the count equals SCAN_DIV-1 is the sample tick.
- row_s is evaluated only on a sample tick.
- Valid sample: exactly one bit of row_s is low. row_idx is the index of that bit.
- No-press sample: row_s = 4'b1111.
- Any other pattern is invalid, covering multi-row and ghosting cases.
- FSM states: SCAN, DEBOUNCE, PRESSED, RELEASE.
- SCAN:
  - On each tick, a valid sample latches cand_row and cand_col and sets match count = 1.
  - If DEBOUNCE_CNT = 1, go to PRESSED and accept the key. Otherwise go to DEBOUNCE.
  - Any non-valid sample advances col one position, rotating 0→1→2→3→0.
- DEBOUNCE:
  - col is frozen.
  - A valid sample with the same row increments the count. When the count reaches DEBOUNCE_CNT, accept the key and go to PRESSED.
  - Any other sample returns to SCAN and advances col.
- Accepting a key: key ← {cand_row, cand_col}, key_valid pulses, key_held ← 1.
- PRESSED:
  - col stays frozen.
  - A no-press sample sets release count = 1 and moves to RELEASE. If DEBOUNCE_CNT = 1, go directly to SCAN instead.
  - All other samples keep the FSM in PRESSED.
- RELEASE:
  - A no-press sample increments the release count. When it reaches DEBOUNCE_CNT, key_held ← 0, go to SCAN and advance col.
  - Any other sample returns to PRESSED with no new strobe.
- A second key pressed while in PRESSED is ignored; no rollover.
- key holds its value until the next accept.
- Counters saturate and have width clog2(max(DEBOUNCE_CNT, REPEAT_CNT) + 1).

## Timing
- Reset values: col = 4'b1110, key = 4'h0, key_valid = 0, key_held = 0, state SCAN, all counters 0.
- Asserting rst in any state returns to these values on the next edge.
- col changes on the clk edge after a sample tick, and the divider restarts at 0.
- Each column has SCAN_DIV cycles to settle. With the 2-flop sync, settle margin is SCAN_DIV-2 cycles.
- Row-to-sample latency is 2 cycles of sync plus the wait to the next tick.
- Press latency: key_valid is asserted 1 cycle after the tick of the first valid sample, plus (DEBOUNCE_CNT-1)·SCAN_DIV cycles.
- key and key_held update in the same cycle that key_valid is high.
- key_held falls 1 cycle after the DEBOUNCE_CNT-th no-press tick.
- Worst-case detect delay for a stable key is 4·SCAN_DIV cycles, one full rotation.

## Configuration
- KEYPAD_REPEAT_EN defined:
  - In PRESSED, a repeat counter increments on each tick.
  - When it reaches REPEAT_CNT, key_valid pulses again with the same key and the counter clears.
  - The counter clears on entry to PRESSED. It also clears on a return from RELEASE to PRESSED.
- KEYPAD_REPEAT_EN undefined: exactly one key_valid per press. The repeat counter is not instantiated.

## Test plan
(SCAN_DIV=4, DEBOUNCE_CNT=3, REPEAT_CNT=8)
- Reset, rows idle → col rotates 1110→1101→1011→0111→1110 every 4 cycles. key_valid stays 0.
- Hold row 2 low while col = 4'b1011 (col 2) → one key_valid with key = 4'hA. col stays frozen and key_held = 1.
- Release the key → key_held drops 9 cycles after the first no-press tick. Scanning resumes at col 3.
- Bounce: row 1 low for 1 tick, high for 1 tick, repeated → no key_valid. Scan continues.
- Two rows low in the same column → no key_valid.
- Assert rst while in PRESSED → all outputs return to their reset values.
- With KEYPAD_REPEAT_EN, hold key 4'h5 → initial strobe followed by a strobe every 32 cycles. Without the macro → exactly 1 strobe.
